// File: rtl/video_timing_pkg.sv
// Shared types and default 720x480 timing for the video timing controller.
package video_timing_pkg;

  // Phases every axis steps through, in this order.
  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StBack  = 2'd1,
    StImage = 2'd2,
    StFront = 2'd3
  } axis_state_e;

  // Width of per-state counters; wide enough for the largest phase (720).
  localparam int unsigned CntW = 10;

  localparam int unsigned H_SYNC_DEF        = 62;
  localparam int unsigned H_BACK_PORCH_DEF  = 60;
  localparam int unsigned H_IMAGE_DEF       = 720;
  localparam int unsigned H_FRONT_PORCH_DEF = 16;
  localparam int unsigned V_SYNC_DEF        = 6;
  localparam int unsigned V_BACK_PORCH_DEF  = 30;
  localparam int unsigned V_IMAGE_DEF       = 480;
  localparam int unsigned V_FRONT_PORCH_DEF = 9;

  // Length of the given phase.
  function automatic logic [CntW-1:0] axis_len(input axis_state_e st,
                                               input logic [CntW-1:0] len_sync,
                                               input logic [CntW-1:0] len_back,
                                               input logic [CntW-1:0] len_image,
                                               input logic [CntW-1:0] len_front);
    logic [CntW-1:0] len;
    case (st)
      StSync:  len = len_sync;
      StBack:  len = len_back;
      StImage: len = len_image;
      default: len = len_front;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Timing outputs and line-request handshake of the video timing controller.
interface video_timing_ctrl_if;
  logic       line_ack;
  logic       hsync;
  logic       vsync;
  logic       in_hblank;
  logic       in_vblank;
  logic       in_image;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       frame_start;
  logic       line_req;
  logic [8:0] line_num;
  logic       underflow;

  // Timing generator side.
  modport master (
    input  line_ack,
    output hsync, vsync, in_hblank, in_vblank, in_image, hpos, vpos,
    output frame_start, line_req, line_num, underflow
  );

  // Renderer / display side.
  modport slave (
    output line_ack,
    input  hsync, vsync, in_hblank, in_vblank, in_image, hpos, vpos,
    input  frame_start, line_req, line_num, underflow
  );
endinterface

// File: rtl/axis_sequencer.sv
// One timing axis: SYNC -> BACK -> IMAGE -> FRONT, each held for its length.
// Also exposes the next-state values so the parent can register outputs
// that line up with the state without an extra cycle of delay.
module axis_sequencer
  import video_timing_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            advance_i,
  input  logic [CntW-1:0] len_sync_i,
  input  logic [CntW-1:0] len_back_i,
  input  logic [CntW-1:0] len_image_i,
  input  logic [CntW-1:0] len_front_i,
  output axis_state_e     state_o,
  output logic [CntW-1:0] count_o,
  output logic            last_o,
  output axis_state_e     nxt_state_o,
  output logic [CntW-1:0] nxt_count_o
);

  axis_state_e     state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] len_cur;

  assign len_cur = axis_len(state_q, len_sync_i, len_back_i, len_image_i, len_front_i);
  assign last_o  = (count_q == len_cur - CntW'(1));

  // Next phase/count: step on advance, wrap to the next phase after the last cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (advance_i) begin
      if (last_o) begin
        count_d = '0;
        unique case (state_q)
          StSync:  state_d = StBack;
          StBack:  state_d = StImage;
          StImage: state_d = StFront;
          StFront: state_d = StSync;
        endcase
      end else begin
        count_d = count_q + CntW'(1);
      end
    end
  end

  // Phase and in-phase count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSync;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state_o     = state_q;
  assign count_o     = count_q;
  assign nxt_state_o = state_d;
  assign nxt_count_o = count_d;

endmodule

// File: rtl/video_timing_ctrl.sv
// Video timing controller: sync/blank/position generation plus a per-line
// source request handshake with sticky underflow detection.
// Optional macro VIDEO_LINE_DOUBLE_EN: fetch one source line per two
// displayed lines (request on even image lines, line_num = image_line >> 1).
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC        = H_SYNC_DEF,
  parameter int unsigned H_BACK_PORCH  = H_BACK_PORCH_DEF,
  parameter int unsigned H_IMAGE       = H_IMAGE_DEF,
  parameter int unsigned H_FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int unsigned V_SYNC        = V_SYNC_DEF,
  parameter int unsigned V_BACK_PORCH  = V_BACK_PORCH_DEF,
  parameter int unsigned V_IMAGE       = V_IMAGE_DEF,
  parameter int unsigned V_FRONT_PORCH = V_FRONT_PORCH_DEF,
  parameter bit          H_INVERT      = 1'b1,
  parameter bit          V_INVERT      = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  video_timing_ctrl_if.master bus
);

  localparam logic [CntW-1:0] HLenSync  = CntW'(H_SYNC);
  localparam logic [CntW-1:0] HLenBack  = CntW'(H_BACK_PORCH);
  localparam logic [CntW-1:0] HLenImage = CntW'(H_IMAGE);
  localparam logic [CntW-1:0] HLenFront = CntW'(H_FRONT_PORCH);
  localparam logic [CntW-1:0] VLenSync  = CntW'(V_SYNC);
  localparam logic [CntW-1:0] VLenBack  = CntW'(V_BACK_PORCH);
  localparam logic [CntW-1:0] VLenImage = CntW'(V_IMAGE);
  localparam logic [CntW-1:0] VLenFront = CntW'(V_FRONT_PORCH);

  // Low only between reset release and the first edge, so that edge enters
  // cycle 0 of the frame (and raises frame_start) instead of skipping it.
  logic run_q;

  axis_state_e     h_state, h_nxt_state, v_state, v_nxt_state;
  logic [CntW-1:0] h_cnt, h_nxt_cnt, v_cnt, v_nxt_cnt;
  logic            h_last, v_last, h_adv, v_adv;

  assign h_adv = run_q;
  assign v_adv = run_q & (h_state == StFront) & h_last;

  axis_sequencer u_h_axis (
    .clk         (clk),
    .reset       (reset),
    .advance_i   (h_adv),
    .len_sync_i  (HLenSync),
    .len_back_i  (HLenBack),
    .len_image_i (HLenImage),
    .len_front_i (HLenFront),
    .state_o     (h_state),
    .count_o     (h_cnt),
    .last_o      (h_last),
    .nxt_state_o (h_nxt_state),
    .nxt_count_o (h_nxt_cnt)
  );

  axis_sequencer u_v_axis (
    .clk         (clk),
    .reset       (reset),
    .advance_i   (v_adv),
    .len_sync_i  (VLenSync),
    .len_back_i  (VLenBack),
    .len_image_i (VLenImage),
    .len_front_i (VLenFront),
    .state_o     (v_state),
    .count_o     (v_cnt),
    .last_o      (v_last),
    .nxt_state_o (v_nxt_state),
    .nxt_count_o (v_nxt_cnt)
  );

  logic unused_seq;
  assign unused_seq = ^{h_cnt, v_state, v_cnt, v_last};

  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            in_hblank_q, in_hblank_d, in_vblank_q, in_vblank_d;
  logic            in_image_q, in_image_d, frame_start_q, frame_start_d;
  logic [9:0]      hpos_q, hpos_d, vpos_q, vpos_d;
  logic            line_req_q, line_req_d, underflow_q, underflow_d;
  logic [8:0]      line_num_q, line_num_d;

  logic            v_nxt_last, succ_img, need_src, req_start, deadline;
  logic [CntW-1:0] succ_idx;
  logic [8:0]      src_num;

  // Which image line follows the current one, and whether it needs a fetch.
  always_comb begin
    v_nxt_last = (v_nxt_cnt ==
                  axis_len(v_nxt_state, VLenSync, VLenBack, VLenImage, VLenFront) - CntW'(1));
    succ_img = 1'b0;
    succ_idx = '0;
    if (v_nxt_state == StBack && v_nxt_last) begin
      succ_img = 1'b1;
    end else if (v_nxt_state == StImage && !v_nxt_last) begin
      succ_img = 1'b1;
      succ_idx = v_nxt_cnt + CntW'(1);
    end
  end

`ifdef VIDEO_LINE_DOUBLE_EN
  assign need_src = ~succ_idx[0];
  assign src_num  = succ_idx[CntW-1:1];
`else
  logic unused_idx;
  assign need_src   = 1'b1;
  assign src_num    = succ_idx[8:0];
  assign unused_idx = succ_idx[CntW-1];
`endif

  // Request opens on entry to h FRONT; deadline is entry to h IMAGE of the
  // requested line.
  assign req_start = run_q & (h_nxt_state == StFront) & (h_nxt_cnt == '0) & succ_img & need_src;
  assign deadline  = (h_nxt_state == StImage) & (h_nxt_cnt == '0);

  // Output next-state, derived from the axes' next state so registered
  // outputs match the state they describe.
  always_comb begin
    hsync_d       = (h_nxt_state == StSync) ^ H_INVERT;
    vsync_d       = (v_nxt_state == StSync) ^ V_INVERT;
    in_hblank_d   = (h_nxt_state != StImage);
    in_vblank_d   = (v_nxt_state != StImage);
    in_image_d    = !(in_hblank_d || in_vblank_d);
    hpos_d        = (h_nxt_state == StImage) ? h_nxt_cnt : '0;
    vpos_d        = (v_nxt_state == StImage) ? v_nxt_cnt : '0;
    frame_start_d = (h_nxt_state == StSync) && (h_nxt_cnt == '0) &&
                    (v_nxt_state == StSync) && (v_nxt_cnt == '0);

    line_req_d  = line_req_q;
    line_num_d  = line_num_q;
    underflow_d = underflow_q;
    // An ack in the deadline cycle wins over underflow.
    if (line_req_q && bus.line_ack) begin
      line_req_d = 1'b0;
    end else if (line_req_q && deadline) begin
      line_req_d  = 1'b0;
      underflow_d = 1'b1;
    end
    if (req_start) begin
      line_req_d = 1'b1;
      line_num_d = src_num;
    end
  end

  // Output registers; reset abandons any pending request without underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q         <= 1'b0;
      hsync_q       <= 1'b1 ^ H_INVERT;
      vsync_q       <= 1'b1 ^ V_INVERT;
      in_hblank_q   <= 1'b1;
      in_vblank_q   <= 1'b1;
      in_image_q    <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_start_q <= 1'b0;
      line_req_q    <= 1'b0;
      line_num_q    <= '0;
      underflow_q   <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      in_hblank_q   <= in_hblank_d;
      in_vblank_q   <= in_vblank_d;
      in_image_q    <= in_image_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_start_q <= frame_start_d;
      line_req_q    <= line_req_d;
      line_num_q    <= line_num_d;
      underflow_q   <= underflow_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.in_hblank   = in_hblank_q;
  assign bus.in_vblank   = in_vblank_q;
  assign bus.in_image    = in_image_q;
  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_req    = line_req_q;
  assign bus.line_num    = line_num_q;
  assign bus.underflow   = underflow_q;

endmodule
